// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - physical register free list with one-entry allocation stage
// Optional release checking is enabled by defining FREE_LIST_DFREE_CHECK_EN.
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_ARCH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           alloc_valid,
  output logic [$clog2(NUM_PREGS)-1:0]   alloc_preg,
  input  logic                           alloc_ready,
  input  logic                           commit_valid,
  input  logic [$clog2(NUM_PREGS)-1:0]   commit_new,
  input  logic [$clog2(NUM_PREGS)-1:0]   commit_old,
  input  logic                           flush,
  output logic [$clog2(NUM_PREGS+1)-1:0] free_count,
  output logic                           err_double_free
);

  localparam int IW = $clog2(NUM_PREGS);
  localparam int CW = $clog2(NUM_PREGS+1);
  localparam logic [NUM_PREGS-1:0] RESET_FREE = {NUM_PREGS{1'b1}} << NUM_ARCH;

  typedef enum logic {EMPTY, STAGED} state_t;

  state_t               state;
  logic [NUM_PREGS-1:0] spec_free;
  logic [NUM_PREGS-1:0] arch_free;
  logic [NUM_PREGS-1:0] release_mask;
  logic [NUM_PREGS-1:0] claim_mask;
  logic [NUM_PREGS-1:0] arch_next;
  logic [NUM_PREGS-1:0] spec_next;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 reload;
  logic [CW-1:0]        pop_next;

  // Lowest-index free preg; scanning downward lets the last hit win.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int i = NUM_PREGS-1; i >= 0; i--) begin
      if (spec_free[i]) begin
        pick_any = 1'b1;
        pick_idx = IW'(i);
      end
    end
  end

  // Selection looks only at the registered spec_free, so a release this cycle
  // becomes visible to the stage one cycle later.
  always_comb begin
    release_mask = '0;
    claim_mask   = '0;
    if (commit_valid) begin
      release_mask[commit_old] = 1'b1;
    end
    arch_next = arch_free | release_mask;
    if (commit_valid) begin
      arch_next[commit_new] = 1'b0;
    end
    reload = (state == EMPTY) || alloc_ready;
    if (pick_any && reload) begin
      claim_mask[pick_idx] = 1'b1;
    end
    if (flush) begin
      spec_next = arch_next;
    end else begin
      spec_next = (spec_free | release_mask) & ~claim_mask;
    end
  end

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      pop_next = pop_next + CW'(spec_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      alloc_valid <= 1'b0;
      alloc_preg  <= '0;
      spec_free   <= RESET_FREE;
      arch_free   <= RESET_FREE;
      free_count  <= CW'(NUM_PREGS - NUM_ARCH);
    end else begin
      spec_free  <= spec_next;
      arch_free  <= arch_next;
      free_count <= pop_next;
      if (flush) begin
        state       <= EMPTY;
        alloc_valid <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (pick_any) begin
              state       <= STAGED;
              alloc_valid <= 1'b1;
              alloc_preg  <= pick_idx;
            end
          end
          STAGED: begin
            if (alloc_ready) begin
              if (pick_any) begin
                alloc_preg <= pick_idx;
              end else begin
                state       <= EMPTY;
                alloc_valid <= 1'b0;
              end
            end
          end
          default: begin
            state       <= EMPTY;
            alloc_valid <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FREE_LIST_DFREE_CHECK_EN
  // Releasing a preg that is already architecturally free, or retiring a preg onto itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_double_free <= 1'b0;
    end else if (commit_valid && (arch_free[commit_old] || (commit_old == commit_new))) begin
      err_double_free <= 1'b1;
    end
  end
`else
  assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// tb/tb_preg_free_list.sv - directed and randomized checks of preg_free_list against a set-based model
module tb_preg_free_list;

  localparam int NP = 64;
  localparam int NA = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic [5:0] alloc_preg;
  logic       alloc_ready;
  logic       commit_valid;
  logic [5:0] commit_new;
  logic [5:0] commit_old;
  logic       flush;
  logic [6:0] free_count;
  logic       err_double_free;

  int vectors = 0;
  int miscompares = 0;

  bit m_spec[NP];
  bit m_arch[NP];
  bit m_valid;
  int m_preg;
  bit m_err;

  preg_free_list #(.NUM_PREGS(NP), .NUM_ARCH(NA)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_preg(alloc_preg), .alloc_ready(alloc_ready),
    .commit_valid(commit_valid), .commit_new(commit_new), .commit_old(commit_old),
    .flush(flush), .free_count(free_count), .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NP; i++) n += int'(m_spec[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_spec[i] = (i >= NA);
      m_arch[i] = (i >= NA);
    end
    m_valid = 0;
    m_preg  = 0;
    m_err   = 0;
  endtask

  task automatic model_edge();
    bit n_spec[NP];
    bit n_arch[NP];
    int p;
    n_spec = m_spec;
    n_arch = m_arch;
    if (commit_valid) begin
`ifdef FREE_LIST_DFREE_CHECK_EN
      if (m_arch[commit_old] || commit_old == commit_new) m_err = 1;
`endif
      n_arch[commit_old] = 1;
      n_arch[commit_new] = 0;
      n_spec[commit_old] = 1;
    end
    if (flush) begin
      n_spec  = n_arch;
      m_valid = 0;
    end else if (!m_valid || alloc_ready) begin
      p = -1;
      for (int i = 0; i < NP; i++) if (m_spec[i] && p < 0) p = i;
      if (p >= 0) begin
        m_valid   = 1;
        m_preg    = p;
        n_spec[p] = 0;
      end else begin
        m_valid = 0;
      end
    end
    m_spec = n_spec;
    m_arch = n_arch;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".alloc_valid"}, 32'(alloc_valid), 32'(m_valid));
    check({tag, ".alloc_preg"}, 32'(alloc_preg), 32'(m_preg));
    check({tag, ".free_count"}, 32'(free_count), 32'(model_count()));
    check({tag, ".err_double_free"}, 32'(err_double_free), 32'(m_err));
  endtask

  task automatic step(input string tag);
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    alloc_ready = 1'b0;
    commit_valid = 1'b0;
    commit_new = '0;
    commit_old = '0;
    flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    step("reset_hold");
    rst = 1'b0;

    // Drain every free preg with the renamer always ready.
    alloc_ready = 1'b1;
    for (int k = 0; k < 33; k++) step("drain");
    check("drain_valid", 32'(alloc_valid), 32'd0);
    check("drain_count", 32'(free_count), 32'd0);

    // A released preg is counted one edge later and staged the edge after.
    alloc_ready = 1'b0;
    commit_valid = 1'b1; commit_new = 6'd32; commit_old = 6'd5;
    step("release");
    check("release_count", 32'(free_count), 32'd1);
    commit_valid = 1'b0;
    step("release_pick");
    check("release_valid", 32'(alloc_valid), 32'd1);
    check("release_preg", 32'(alloc_preg), 32'd5);

    // Stage preg 40 and hold it with no handshake.
    do_reset();
    alloc_ready = 1'b1;
    for (int k = 0; k < 9; k++) step("to40");
    alloc_ready = 1'b0;
    check("staged40", 32'(alloc_preg), 32'd40);
    for (int k = 0; k < 10; k++) begin
      step("hold40");
      check("hold40_preg", 32'(alloc_preg), 32'd40);
    end

    // Flush with a same-cycle commit and handshake.
    do_reset();
    alloc_ready = 1'b1;
    for (int k = 0; k < 4; k++) step("alloc4");
    commit_valid = 1'b1; commit_new = 6'd32; commit_old = 6'd1; flush = 1'b1;
    step("flush");
    check("flush_valid", 32'(alloc_valid), 32'd0);
    check("flush_count", 32'(free_count), 32'd32);
    commit_valid = 1'b0; flush = 1'b0;
    step("after_flush");
    check("after_flush_preg", 32'(alloc_preg), 32'd1);

    // Release of a preg that is already architecturally free.
    alloc_ready = 1'b0;
    commit_valid = 1'b1; commit_new = 6'd2; commit_old = 6'd40;
    step("dfree");
`ifdef FREE_LIST_DFREE_CHECK_EN
    check("dfree_flag", 32'(err_double_free), 32'd1);
`else
    check("dfree_flag", 32'(err_double_free), 32'd0);
`endif
    commit_valid = 1'b0;
    for (int k = 0; k < 3; k++) step("dfree_hold");

    // Reset arriving while preg 50 is staged and a commit is pending.
    do_reset();
    alloc_ready = 1'b1;
    for (int k = 0; k < 19; k++) step("to50");
    check("staged50", 32'(alloc_preg), 32'd50);
    commit_valid = 1'b1; commit_new = 6'd50; commit_old = 6'd3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    step("rst_mid_hold");
    rst = 1'b0;
    commit_valid = 1'b0;
    step("rst_release");
    check("rst_release_preg", 32'(alloc_preg), 32'd32);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      alloc_ready  = 1'($urandom_range(0, 1));
      commit_valid = ($urandom_range(0, 3) == 0);
      commit_new   = 6'($urandom_range(0, NP-1));
      commit_old   = 6'($urandom_range(0, NP-1));
      flush        = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 199) == 0);
      step("random");
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
